// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I/M decode and one-entry ID->EX issue register driving the ALU
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [3:0]      select_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_write_o,
  output logic            illegal_o
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SLL  = 4'b0100;
  localparam logic [3:0] SEL_SRL  = 4'b0101;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_MUL  = 4'b1000;
  localparam logic [3:0] SEL_DIV  = 4'b1001;
  localparam logic [3:0] SEL_SLT  = 4'b1010;
  localparam logic [3:0] SEL_NONE = 4'b1111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] data1_q, data1_d;
  logic [XLEN-1:0] data2_q, data2_d;
  logic [3:0]      select_q, select_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            legal;
  logic            accept;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    legal     = 1'b0;
    select_d  = SEL_NONE;
    data1_d   = '0;
    data2_d   = '0;
    rd_addr_d = instr_i[11:7];
    case (opcode)
      OPC_OP: begin
        data1_d = rs1_data_i;
        data2_d = rs2_data_i;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  select_d = SEL_ADD;
            3'b001:  select_d = SEL_SLL;
            3'b010:  select_d = SEL_SLT;
            3'b100:  select_d = SEL_XOR;
            3'b101:  select_d = SEL_SRL;
            3'b110:  select_d = SEL_OR;
            3'b111:  select_d = SEL_AND;
            default: legal    = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal    = 1'b1;
            select_d = SEL_SUB;
          end else if (funct3 == 3'b101) begin
            legal    = 1'b1;
            select_d = SEL_SRA;
          end
        end else if (funct7 == F7_MULD && ENABLE_M) begin
          if (funct3 == 3'b000) begin
            legal    = 1'b1;
            select_d = SEL_MUL;
          end else if (funct3 == 3'b100) begin
            legal    = 1'b1;
            select_d = SEL_DIV;
          end
        end
      end
      OPC_OPIMM: begin
        data1_d = rs1_data_i;
        data2_d = imm_i;
        legal   = 1'b1;
        case (funct3)
          3'b000: select_d = SEL_ADD;
          3'b010: select_d = SEL_SLT;
          3'b100: select_d = SEL_XOR;
          3'b110: select_d = SEL_OR;
          3'b111: select_d = SEL_AND;
          3'b001: begin
            data2_d  = shamt;
            select_d = SEL_SLL;
            legal    = (funct7 == F7_BASE);
          end
          3'b101: begin
            data2_d  = shamt;
            select_d = (funct7 == F7_ALT) ? SEL_SRA : SEL_SRL;
            legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal    = 1'b1;
        select_d = SEL_ADD;
        data2_d  = imm_u;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        select_d = SEL_ADD;
        data1_d  = pc_i;
        data2_d  = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings still flow down the pipe, but as an inert bubble-like op.
    if (!legal) begin
      select_d = SEL_NONE;
      data1_d  = '0;
      data2_d  = '0;
    end
    reg_write_d = legal && (rd_addr_d != 5'd0);
    illegal_d   = !legal;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      select_q    <= SEL_AND;
      rd_addr_q   <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        data1_q     <= data1_d;
        data2_q     <= data2_d;
        select_q    <= select_d;
        rd_addr_q   <= rd_addr_d;
        reg_write_q <= reg_write_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign data1_o     = data1_q;
  assign data2_o     = data2_q;
  assign select_o    = select_q;
  assign rd_addr_o   = rd_addr_q;
  assign reg_write_o = reg_write_q;
  assign illegal_o   = illegal_q;

endmodule
